// File: rtl/pwm_gen.sv
// Complementary gate-drive PWM: fixed on-time, programmable off-time, dead-time gaps.
// Requests an off_div recompute once per UPDATE_DIV periods and samples it at the period boundary.
module pwm_gen #(
    parameter int unsigned ON_TIME    = 40,
    parameter int unsigned CNT_WIDTH  = 18,
    parameter int unsigned DEAD_TIME  = 4,
    parameter int unsigned MIN_OFF    = 2,
    parameter int unsigned UPDATE_DIV = 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 enable,
    input  logic                 fault,
    input  logic [CNT_WIDTH-1:0] off_div,
    input  logic                 pwm_rdy,
    output logic                 pwm_en,
    output logic                 gate_hi,
    output logic                 gate_lo,
    output logic                 period_done,
    output logic                 fault_lat
);

    localparam int unsigned PER_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ON,
        S_DEAD_A,
        S_OFF,
        S_DEAD_B,
        S_FAULT
    } state_t;

    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic [CNT_WIDTH-1:0] off_lat, off_lat_n;
    logic [PER_W-1:0]     per_cnt, per_cnt_n;
    logic                 last_c;
    logic                 last_n;
    logic                 pwm_en_n;

    // Next-state, phase counter, period counter and off-time load.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        off_lat_n = off_lat;
        per_cnt_n = per_cnt;
        last_c    = (state == S_DEAD_B && cnt == CNT_WIDTH'(1)) ||
                    (DEAD_TIME == 0 && state == S_OFF && cnt == CNT_WIDTH'(1));

        case (state)
            S_IDLE: begin
                if (enable) state_n = S_ON;
            end
            S_ON: begin
                if (cnt == CNT_WIDTH'(1)) begin
                    if (DEAD_TIME != 0) begin
                        state_n = S_DEAD_A;
                        cnt_n   = CNT_WIDTH'(DEAD_TIME);
                    end else begin
                        state_n = S_OFF;
                        cnt_n   = off_lat;
                    end
                end else begin
                    cnt_n = cnt - CNT_WIDTH'(1);
                end
            end
            S_DEAD_A: begin
                if (cnt == CNT_WIDTH'(1)) begin
                    state_n = S_OFF;
                    cnt_n   = off_lat;
                end else begin
                    cnt_n = cnt - CNT_WIDTH'(1);
                end
            end
            S_OFF: begin
                if (cnt == CNT_WIDTH'(1)) begin
                    if (DEAD_TIME != 0) begin
                        state_n = S_DEAD_B;
                        cnt_n   = CNT_WIDTH'(DEAD_TIME);
                    end else begin
                        state_n = enable ? S_ON : S_IDLE;
                    end
                end else begin
                    cnt_n = cnt - CNT_WIDTH'(1);
                end
            end
            S_DEAD_B: begin
                if (cnt == CNT_WIDTH'(1)) begin
                    state_n = enable ? S_ON : S_IDLE;
                end else begin
                    cnt_n = cnt - CNT_WIDTH'(1);
                end
            end
            S_FAULT: begin
                if (!enable) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        if (last_c) begin
            per_cnt_n = (per_cnt == PER_W'(UPDATE_DIV - 1)) ? '0 : per_cnt + PER_W'(1);
        end

        // Fault overrides every transition, including the period boundary.
        if (fault) state_n = S_FAULT;

        if (state_n == S_IDLE || state_n == S_FAULT) begin
            per_cnt_n = '0;
            cnt_n     = '0;
        end

        if (state_n == S_ON && state != S_ON) begin
            cnt_n = CNT_WIDTH'(ON_TIME);
            if (pwm_rdy) begin
                off_lat_n = (off_div < CNT_WIDTH'(MIN_OFF)) ? CNT_WIDTH'(MIN_OFF) : off_div;
            end
        end

        last_n   = (state_n == S_DEAD_B && cnt_n == CNT_WIDTH'(1)) ||
                   (DEAD_TIME == 0 && state_n == S_OFF && cnt_n == CNT_WIDTH'(1));
        pwm_en_n = (state_n == S_OFF) && (state != S_OFF) && (per_cnt_n == '0);
    end

    // Outputs are decoded from the next state so they are registered yet phase-aligned.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            off_lat     <= CNT_WIDTH'(ON_TIME);
            per_cnt     <= '0;
            pwm_en      <= 1'b0;
            gate_hi     <= 1'b0;
            gate_lo     <= 1'b0;
            period_done <= 1'b0;
            fault_lat   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            off_lat     <= off_lat_n;
            per_cnt     <= per_cnt_n;
            pwm_en      <= pwm_en_n;
            gate_hi     <= (state_n == S_ON);
            gate_lo     <= (state_n == S_OFF);
            period_done <= last_n;
            fault_lat   <= (state_n == S_FAULT);
        end
    end

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen: default instance plus a DEAD_TIME=0 / UPDATE_DIV=3 instance.
module tb_pwm_gen;

    localparam int unsigned W   = 18;
    localparam int          TMO = 3000;

    localparam int S_HI = 0, S_LO = 1, S_PD = 2, S_EN = 3;
    localparam int S_PD2 = 6, S_EN2 = 7;

    logic         clk;
    logic         n_rst;
    logic         enable;
    logic         fault;
    logic [W-1:0] off_div;
    logic         pwm_rdy;

    logic hi, lo, pd, en, flt;
    logic hi2, lo2, pd2, en2, flt2;

    int n_checks = 0;
    int n_errors = 0;
    int overlap  = 0;

    pwm_gen u_dut (
        .clk(clk), .n_rst(n_rst), .enable(enable), .fault(fault),
        .off_div(off_div), .pwm_rdy(pwm_rdy), .pwm_en(en),
        .gate_hi(hi), .gate_lo(lo), .period_done(pd), .fault_lat(flt)
    );

    pwm_gen #(.DEAD_TIME(0), .UPDATE_DIV(3)) u_dut2 (
        .clk(clk), .n_rst(n_rst), .enable(enable), .fault(fault),
        .off_div(off_div), .pwm_rdy(pwm_rdy), .pwm_en(en2),
        .gate_hi(hi2), .gate_lo(lo2), .period_done(pd2), .fault_lat(flt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((hi && lo) || (hi2 && lo2)) overlap++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            S_HI:    return hi;
            S_LO:    return lo;
            S_PD:    return pd;
            S_EN:    return en;
            S_PD2:   return pd2;
            S_EN2:   return en2;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_high(input int sel, output int n);
        n = 0;
        while (!sig(sel) && n < TMO) begin
            tick();
            n++;
        end
    endtask

    task automatic count_high(input int sel, output int n);
        n = 0;
        while (sig(sel) && n < TMO) begin
            n++;
            tick();
        end
    endtask

    task automatic next_pd(input int sel_pd, input int sel_en, output int n, output int pens);
        n    = 0;
        pens = 0;
        do begin
            tick();
            n++;
            if (sig(sel_en)) pens++;
        end while (!sig(sel_pd) && n < TMO);
    endtask

    initial begin
        int n, p;
        n_rst   = 1'b1;
        enable  = 1'b0;
        fault   = 1'b0;
        off_div = W'(100);
        pwm_rdy = 1'b1;
        #2 n_rst = 1'b0;
        ticks(3);
        check("reset_outputs", int'({hi, lo, en, pd, flt}), 0);
        check("reset_outputs2", int'({hi2, lo2, en2, pd2, flt2}), 0);
        n_rst = 1'b1;
        ticks(3);
        check("idle_without_enable", int'(hi), 0);

        // Basic period with defaults
        enable = 1'b1;
        tick();
        check("on_start", int'(hi), 1);
        count_high(S_HI, n);  check("basic_on_len", n, 40);
        wait_high(S_LO, n);   check("basic_dead_a", n, 4);
        check("basic_pwm_en_first_off", int'(en), 1);
        count_high(S_LO, n);  check("basic_off_len", n, 100);
        wait_high(S_PD, n);   check("basic_dead_b_pd", n, 3);
        next_pd(S_PD, S_EN, n, p);
        check("basic_period", n, 148);
        check("basic_pwm_en_count", p, 1);

        // Clamp and hold
        off_div = W'(0);
        tick();
        count_high(S_HI, n);
        wait_high(S_LO, n);
        count_high(S_LO, n);  check("clamp_off_len", n, 2);
        off_div = W'(500);
        pwm_rdy = 1'b0;
        wait_high(S_PD, n);
        tick();
        wait_high(S_LO, n);
        count_high(S_LO, n);  check("hold_off_len", n, 2);
        pwm_rdy = 1'b1;
        wait_high(S_PD, n);
        tick();
        wait_high(S_LO, n);

        // Enable drop mid-OFF on the 500-cycle period
        ticks(10);
        enable  = 1'b0;
        off_div = W'(100);
        count_high(S_LO, n);  check("drop_rest_of_off", n, 490);
        wait_high(S_PD, n);   check("drop_pd_after_dead", n, 3);
        tick();
        check("drop_idle_hi", int'(hi), 0);
        check("drop_idle_lo", int'(lo), 0);
        ticks(3);
        check("drop_idle_stays", int'(hi), 0);
        enable = 1'b1;
        tick();
        check("reenable_on", int'(hi), 1);

        // Fault on ON cycle 10
        ticks(9);
        fault = 1'b1;
        tick();
        check("fault_gate_hi", int'(hi), 0);
        check("fault_lat_set", int'(flt), 1);
        fault = 1'b0;
        ticks(2);
        check("fault_hold_with_enable", int'(flt), 1);
        enable = 1'b0;
        tick();
        check("fault_to_idle", int'(flt), 0);
        pwm_rdy = 1'b0;
        off_div = W'(7);
        enable  = 1'b1;
        tick();
        check("post_fault_on", int'(hi), 1);
        count_high(S_HI, n);  check("post_fault_on_len", n, 40);
        wait_high(S_LO, n);
        count_high(S_LO, n);  check("off_lat_retained", n, 100);

        // Asynchronous reset mid-OFF
        wait_high(S_PD, n);
        tick();
        wait_high(S_LO, n);
        ticks(5);
        check("pre_reset_lo", int'(lo), 1);
        #2 n_rst = 1'b0;
        #1 check("async_reset_outputs", int'({hi, lo, en, pd, flt}), 0);
        off_div = W'(100);
        ticks(2);
        n_rst = 1'b1;
        tick();
        check("post_reset_on", int'(hi), 1);
        count_high(S_HI, n);
        wait_high(S_LO, n);
        count_high(S_LO, n);  check("post_reset_off_default", n, 40);

        // UPDATE_DIV=3, DEAD_TIME=0 instance
        tick();
        n_rst   = 1'b0;
        pwm_rdy = 1'b1;
        off_div = W'(100);
        enable  = 1'b1;
        tick();
        n_rst = 1'b1;
        for (int k = 0; k < 7; k++) begin
            next_pd(S_PD2, S_EN2, n, p);
            check($sformatf("div3_period_%0d", k), n, 140);
            check($sformatf("div3_pwm_en_%0d", k), p, (k % 3 == 0) ? 1 : 0);
        end
        enable = 1'b0;
        ticks(2);

        check("gates_never_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
